reg_dump_tx: RTL

- Register-file readback sequencer for the debug path.
- On a start pulse it drives register addresses 0..NUM_REGS-1 into the register file's debug read port and captures each word.
- Each word is serialized MSB-byte-first onto a byte stream with a valid/ready handshake; the stream feeds the debug UART transmitter.
- It is the address-generating counterpart of the instruction-field address decode.

---
 rtl/reg_dump_tx.sv | 125 ++++++++++++
 1 files changed

// File: rtl/reg_dump_tx.sv
// Register-file readback sequencer: walks addresses 0..NUM_REGS-1, captures each word and
// streams it MSB byte first over valid/ready. Optional trailing XOR checksum: REG_DUMP_CHECKSUM_EN.
module reg_dump_tx #(
  parameter int NUM_REGS = 32,
  parameter int ADDR_W   = 5,
  parameter int DATA_W   = 32,
  parameter int RD_LAT   = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [DATA_W-1:0] rd_data,
  output logic [7:0]        tx_byte,
  output logic              tx_valid,
  input  logic              tx_ready,
  output logic              busy,
  output logic              done,
  output logic [2:0]        state_dbg
);

  localparam int NBYTES = DATA_W / 8;
  localparam int BI_W   = (NBYTES > 1) ? $clog2(NBYTES) : 1;

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_WAIT = 3'd1;
  localparam logic [2:0] S_SEND = 3'd2;
  localparam logic [2:0] S_NEXT = 3'd3;
  localparam logic [2:0] S_FIN  = 3'd4;
`ifdef REG_DUMP_CHECKSUM_EN
  localparam logic [2:0] S_CSUM = 3'd5;
  logic [7:0] csum;
`endif

  logic [2:0]        state;
  logic [DATA_W-1:0] shreg;
  logic [BI_W-1:0]   bidx;
  logic [1:0]        wcnt;

  // Handshake: a byte moves on any rising edge where tx_valid && tx_ready; once raised,
  // tx_valid and tx_byte hold unchanged until that edge.
`ifdef REG_DUMP_CHECKSUM_EN
  assign tx_valid = (state == S_SEND) || (state == S_CSUM);
`else
  assign tx_valid = (state == S_SEND);
`endif
  assign tx_byte   = shreg[DATA_W-1 -: 8];
  assign busy      = (state != S_IDLE);
  assign done      = (state == S_FIN);
  assign state_dbg = state;

  // rd_data is sampled on the RD_LAT-th rising edge after rd_addr takes its new value.
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= S_IDLE;
      rd_addr <= '0;
      shreg   <= '0;
      bidx    <= '0;
      wcnt    <= '0;
`ifdef REG_DUMP_CHECKSUM_EN
      csum    <= '0;
`endif
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            rd_addr <= '0;
            wcnt    <= '0;
            bidx    <= '0;
`ifdef REG_DUMP_CHECKSUM_EN
            csum    <= '0;
`endif
            state   <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (wcnt == 2'(RD_LAT - 1)) begin
            shreg <= rd_data;
            wcnt  <= '0;
            state <= S_SEND;
          end else begin
            wcnt <= wcnt + 2'd1;
          end
        end
        S_SEND: begin
          if (tx_ready) begin
            shreg <= shreg << 8;
`ifdef REG_DUMP_CHECKSUM_EN
            csum  <= csum ^ shreg[DATA_W-1 -: 8];
`endif
            if (bidx == BI_W'(NBYTES - 1)) begin
              bidx  <= '0;
              state <= S_NEXT;
            end else begin
              bidx <= bidx + BI_W'(1);
            end
          end
        end
        S_NEXT: begin
          if (rd_addr == ADDR_W'(NUM_REGS - 1)) begin
`ifdef REG_DUMP_CHECKSUM_EN
            // Park the checksum in the top byte so it leaves through the normal tx_byte path.
            shreg <= {csum, {(DATA_W-8){1'b0}}};
            state <= S_CSUM;
`else
            state <= S_FIN;
`endif
          end else begin
            rd_addr <= rd_addr + ADDR_W'(1);
            wcnt    <= '0;
            state   <= S_WAIT;
          end
        end
`ifdef REG_DUMP_CHECKSUM_EN
        S_CSUM: begin
          if (tx_ready) state <= S_FIN;
        end
`endif
        S_FIN:   state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
